latch_tester: RTL

On-chip exerciser that drives the D/EN inputs of a level-sensitive D-latch under test and reads its Q output back, checking both transparency and hold behaviour over a sequence of test vectors. It sits inside the TinyTapeout top level beside the latch. Its stimulus outputs map onto the latch inputs, and its status outputs map onto `uo_out`, so a run can be started and read back from the pins without external sequencing.

---
 rtl/latch_tester_pkg.sv | 24 ++
 rtl/latch_tester_if.sv | 28 ++
 rtl/latch_tester_sync2.sv | 24 ++
 rtl/latch_tester.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/latch_tester_pkg.sv
// rtl/latch_tester_pkg.sv - shared types and constants for the latch exerciser
package latch_tester_pkg;

  localparam int IDX_W = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps s[7], s[5], s[4], s[3]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_OPEN,
    ST_LATCH,
    ST_INV,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/latch_tester_if.sv
// rtl/latch_tester_if.sv - stimulus/status bundle between the exerciser and its host
interface latch_tester_if #(
  parameter int ERR_W = 8
);
  import latch_tester_pkg::*;

  logic             ena;
  logic             start;
  logic             latch_q;
  logic             latch_d;
  logic             latch_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] vec_idx;

  modport master (
    output ena, start, latch_q,
    input  latch_d, latch_en, busy, done, pass, err_count, vec_idx
  );

  modport slave (
    input  ena, start, latch_q,
    output latch_d, latch_en, busy, done, pass, err_count, vec_idx
  );

endinterface

// File: rtl/latch_tester_sync2.sv
// rtl/latch_tester_sync2.sv - two-flop synchronizer for the asynchronous latch Q
module latch_tester_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/latch_tester.sv
// rtl/latch_tester.sv - D-latch transparency/hold exerciser; LATCH_TESTER_LFSR_EN selects LFSR pattern
module latch_tester #(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 3,
  parameter int ERR_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  latch_tester_if.slave bus
);
  import latch_tester_pkg::*;

  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_latch_d;
  logic             r_latch_en;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] r_idx;

  logic             w_q_s;
  logic             w_b;
  logic             w_b_seed;
  logic             w_b_adv;
  logic             w_settle_last;
  logic [ERR_W-1:0] w_err_inc;

  latch_tester_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.latch_q),
    .o_q   (w_q_s)
  );

`ifdef LATCH_TESTER_LFSR_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;
  assign w_lfsr_next = lfsr_next(r_lfsr);
  assign w_b         = r_lfsr[0];
  assign w_b_seed    = LFSR_SEED[0];
  assign w_b_adv     = w_lfsr_next[0];
`else
  assign w_b         = r_idx[0];
  assign w_b_seed    = 1'b0;
  assign w_b_adv     = ~r_idx[0];
`endif

  assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_err_inc     = (&r_err) ? r_err : r_err + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_latch_d  <= 1'b0;
      r_latch_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_idx      <= '0;
`ifdef LATCH_TESTER_LFSR_EN
      r_lfsr     <= LFSR_SEED;
`endif
    end else if (bus.ena) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_err      <= '0;
            r_idx      <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
            r_latch_en <= 1'b0;
            r_latch_d  <= w_b_seed;
`ifdef LATCH_TESTER_LFSR_EN
            r_lfsr     <= LFSR_SEED;
`endif
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_latch_en <= 1'b1;
          r_cnt      <= '0;
          r_state    <= ST_OPEN;
        end
        ST_OPEN: begin
          if (w_settle_last) begin
            if (w_q_s != w_b) r_err <= w_err_inc;
            r_latch_en <= 1'b0;
            r_state    <= ST_LATCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LATCH: begin
          // Flip D with EN low: a good latch must keep the old value
          r_latch_d <= ~w_b;
          r_cnt     <= '0;
          r_state   <= ST_INV;
        end
        ST_INV: begin
          if (w_settle_last) begin
            if (w_q_s != w_b) r_err <= w_err_inc;
            r_state <= ST_NEXT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          r_idx <= r_idx + 1'b1;
`ifdef LATCH_TESTER_LFSR_EN
          r_lfsr <= w_lfsr_next;
`endif
          if (r_idx == IDX_W'(NUM_VECTORS - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0);
            r_state <= ST_DONE;
          end else begin
            r_latch_d <= w_b_adv;
            r_state   <= ST_SETUP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.latch_d   = r_latch_d;
  assign bus.latch_en  = r_latch_en;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.vec_idx   = r_idx;

endmodule
